spiflash_ctrl: RTL and testbench

SPI master and two-port arbiter for the team's byte-wide SPI NOR flash simulation model used by the SDC testbench. It accepts read and write byte requests from two requesters and grants them round-robin. Each granted request becomes one 48-bit SPI mode-0 transaction: 32-bit address, then 8-bit command, then 8-bit data, all MSB first. The read byte or write completion goes back to the granted requester.

---
 rtl/spiflash_ctrl_pkg.sv | 14 +
 rtl/spiflash_ctrl_spiclkgen.sv | 35 +++
 rtl/spiflash_ctrl.sv | 112 +++++++++++
 tb/tb_spiflash_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spiflash_ctrl_pkg.sv
// Shared constants and state type for the SPI flash master/arbiter.
package spiflash_ctrl_pkg;

  localparam logic [7:0] SPIFLASH_CMD_READ  = 8'h01;
  localparam logic [7:0] SPIFLASH_CMD_WRITE = 8'h02;
  localparam int         SPIFLASH_FRAME     = 48;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } spiflashctrlstate;

endpackage

// File: rtl/spiflash_ctrl_spiclkgen.sv
// SCK divider: counts DIV clk cycles per phase, emits rise/fall strobes one cycle before SCK moves.
module spiclkgen #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic toggle_en,
  output logic SCK,
  output logic tick,
  output logic SckRise,
  output logic SckFall
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] div_cnt;

  assign tick    = en & (div_cnt == CW'(DIV - 1));
  assign SckRise = tick & toggle_en & ~SCK;
  assign SckFall = tick & toggle_en & SCK;

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
      SCK     <= 1'b0;
    end else begin
      if (!en || tick) div_cnt <= '0;
      else             div_cnt <= div_cnt + 1'b1;
      if (SckRise)      SCK <= 1'b1;
      else if (SckFall) SCK <= 1'b0;
    end
  end

endmodule

// File: rtl/spiflash_ctrl.sv
// Two-port round-robin arbiter feeding a 48-bit mode-0 SPI master (addr, cmd, data; MSB first).
//   state | meaning
//   IDLE  | CS high, waiting for a request; grants and loads the frame
//   SHIFT | CS low, clocking 48 bits out, capturing the read byte
//   HOLD  | CS high for DIV cycles before the next grant
module spiflash_ctrl
  import spiflash_ctrl_pkg::*;
#(
  parameter int DIV = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [1:0]      ReqValid,
  output logic [1:0]      ReqReady,
  input  logic [1:0]      ReqWrite,
  input  logic [1:0][31:0] ReqAdr,
  input  logic [1:0][7:0] ReqWData,
  output logic [1:0]      RspValid,
  output logic [7:0]      RspRData,
  output logic            SCK,
  output logic            CS,
  output logic            MOSI,
  input  logic            MISO
);

  spiflashctrlstate state_q, state_d;

  logic        ptr, port, gport, grant;
  logic        is_write, last_bit;
  logic [47:0] shreg;
  logic [5:0]  bitcnt;
  logic [7:0]  rdreg;
  logic        tick, sck_rise, sck_fall;

  spiclkgen #(.DIV(DIV)) u_clkgen (
    .clk      (clk),
    .reset    (reset),
    .en       (state_q != IDLE),
    .toggle_en(state_q == SHIFT),
    .SCK      (SCK),
    .tick     (tick),
    .SckRise  (sck_rise),
    .SckFall  (sck_fall)
  );

  always_comb begin
    state_d  = state_q;
    ReqReady = 2'b00;
    grant    = 1'b0;
    gport    = ptr;
    case (state_q)
      IDLE: if (|ReqValid) begin
        grant    = 1'b1;
        gport    = (&ReqValid) ? ptr : ReqValid[1];
        ReqReady = 2'b01 << gport;
        state_d  = SHIFT;
      end
      SHIFT: if (sck_fall && last_bit) state_d = HOLD;
      HOLD:  if (tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      ptr      <= 1'b0;
      port     <= 1'b0;
      is_write <= 1'b0;
      last_bit <= 1'b0;
      shreg    <= '0;
      bitcnt   <= '0;
      rdreg    <= '0;
      CS       <= 1'b1;
      RspValid <= 2'b00;
    end else begin
      state_q  <= state_d;
      RspValid <= 2'b00;
      if (grant) begin
        ptr      <= ~gport;
        port     <= gport;
        is_write <= ReqWrite[gport];
        shreg    <= {ReqAdr[gport],
                     ReqWrite[gport] ? SPIFLASH_CMD_WRITE : SPIFLASH_CMD_READ,
                     ReqWData[gport]};
        bitcnt   <= '0;
        rdreg    <= '0;
        CS       <= 1'b0;
      end
      if (state_q == SHIFT && sck_rise && bitcnt == 6'(SPIFLASH_FRAME - 1))
        last_bit <= 1'b1;
      if (state_q == SHIFT && sck_fall) begin
        shreg  <= {shreg[46:0], 1'b0};
        bitcnt <= bitcnt + 1'b1;
        // data byte arrives one bit early: MISO sampled at the falls ending bits 39..46
        if (!is_write && bitcnt >= 6'd39 && bitcnt <= 6'd46)
          rdreg <= {rdreg[6:0], MISO};
        if (last_bit) begin
          CS       <= 1'b1;
          shreg    <= '0;
          bitcnt   <= '0;
          last_bit <= 1'b0;
        end
      end
      if (state_q == HOLD && tick) RspValid <= 2'b01 << port;
    end
  end

  assign MOSI     = shreg[47];
  assign RspRData = rdreg;

endmodule

// File: tb/tb_spiflash_ctrl.sv
// Self-checking bench for spiflash_ctrl with a behavioural SPI NOR flash and a scoreboard.
module tb_spiflash_ctrl;

  localparam int DIV     = 2;
  localparam int RSP_LAT = 97 * DIV + 1;
  localparam int NB2B    = 10;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       ReqValid, ReqReady, ReqWrite, RspValid;
  logic [1:0][31:0] ReqAdr;
  logic [1:0][7:0]  ReqWData;
  logic [7:0]       RspRData;
  logic             SCK, CS, MOSI, MISO;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  spiflash_ctrl #(.DIV(DIV)) dut (
    .clk(clk), .reset(reset),
    .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqWrite(ReqWrite),
    .ReqAdr(ReqAdr), .ReqWData(ReqWData),
    .RspValid(RspValid), .RspRData(RspRData),
    .SCK(SCK), .CS(CS), .MOSI(MOSI), .MISO(MISO)
  );

  // behavioural flash: samples MOSI on SCK rise, drives read data from the rise of bit 39
  logic [7:0]  fmem [logic [31:0]];
  logic [47:0] fsh;
  logic [7:0]  frd;
  bit          frd_mode;
  int          fbits = 0;
  int          last_bits = 0;
  bit          rise_mosi [48];
  bit          ovr_en = 1'b0;
  logic [7:0]  ovr_val = 8'h00;

  initial MISO = 1'b0;

  always @(negedge CS) begin
    fbits    = 0;
    frd_mode = 1'b0;
  end

  always @(posedge CS) last_bits = fbits;

  always @(posedge SCK) begin
    if (CS === 1'b0) begin
      if (fbits < 48) rise_mosi[fbits] = MOSI;
      fsh = {fsh[46:0], MOSI};
      fbits++;
      if (fbits == 40 && fsh[7:0] == 8'h01) begin
        frd_mode = 1'b1;
        frd  = ovr_en ? ovr_val : (fmem.exists(fsh[39:8]) ? fmem[fsh[39:8]] : 8'h00);
        MISO = frd[7];
      end else if (frd_mode && fbits > 40 && fbits < 48) begin
        MISO = frd[7 - (fbits - 40)];
      end
      if (fbits == 48 && fsh[15:8] == 8'h02) fmem[fsh[47:16]] = fsh[7:0];
    end
  end

  // shortest CS-high run seen between two CS-low windows
  int hi_run = 0;
  int min_gap = 1000000;
  bit seen_low = 1'b0;
  always @(negedge clk) begin
    if (CS === 1'b1) hi_run++;
    else if (CS === 1'b0) begin
      if (seen_low && hi_run > 0 && hi_run < min_gap) min_gap = hi_run;
      hi_run   = 0;
      seen_low = 1'b1;
    end
  end

  // reference model: contents as written, and the round-robin favourite
  logic [7:0] ref_mem [logic [31:0]];
  bit         ref_ptr = 1'b0;

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    reset    = 1'b1;
    ReqValid = 2'b00;
    ReqWrite = 2'b00;
    ReqAdr   = '0;
    ReqWData = '0;
    repeat (2) @(negedge clk);
    reset   = 1'b0;
    ref_ptr = 1'b0;
  endtask

  // one request on port p; reports grant vector, wait before grant, response vector, data, latency
  task automatic run_txn(input int p, input bit wr, input logic [31:0] adr, input logic [7:0] wd,
                         output logic [1:0] rdy, output int wt, output logic [1:0] rsp,
                         output logic [7:0] rd, output int lat);
    @(negedge clk);
    ReqValid[p] = 1'b1;
    ReqWrite[p] = wr;
    ReqAdr[p]   = adr;
    ReqWData[p] = wd;
    #1;
    wt = 0;
    while (ReqReady == 2'b00 && wt < 500) begin
      @(negedge clk); #1; wt++;
    end
    rdy = ReqReady;
    if (rdy != 2'b00) ref_ptr = (p == 0);
    @(negedge clk);
    ReqValid[p] = 1'b0;
    ReqWrite[p] = ~wr;
    ReqAdr[p]   = $urandom;
    ReqWData[p] = 8'($urandom);
    #1;
    lat = 1;
    while (RspValid == 2'b00 && lat < 500) begin
      @(negedge clk); #1; lat++;
    end
    rsp = RspValid;
    rd  = RspRData;
    if (rsp == 2'b00) lat = -1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk); #1;
    checks++; if (CS !== 1'b1) $display("FAIL reset_cs got %b want 1", CS); else passed++;
    checks++; if (SCK !== 1'b0) $display("FAIL reset_sck got %b want 0", SCK); else passed++;
    checks++; if (MOSI !== 1'b0) $display("FAIL reset_mosi got %b want 0", MOSI); else passed++;
    checks++; if (ReqReady !== 2'b00) $display("FAIL reset_ready got %b want 00", ReqReady); else passed++;
    checks++; if (RspValid !== 2'b00) $display("FAIL reset_rspvalid got %b want 00", RspValid); else passed++;
    checks++; if (RspRData !== 8'h00) $display("FAIL reset_rdata got %h want 00", RspRData); else passed++;
  endtask

  task automatic test_write_read();
    logic [1:0] rdy, rsp;
    logic [7:0] rd;
    int wt, lat;
    run_txn(0, 1'b1, 32'h0000_0005, 8'hA5, rdy, wt, rsp, rd, lat);
    ref_mem[32'h5] = 8'hA5;
    checks++; if (rdy !== 2'b01) $display("FAIL wr_grant got %b want 01", rdy); else passed++;
    checks++; if (rsp !== 2'b01) $display("FAIL wr_rspport got %b want 01", rsp); else passed++;
    checks++; if (lat != RSP_LAT) $display("FAIL wr_latency got %0d want %0d", lat, RSP_LAT); else passed++;
    checks++; if (rd !== 8'h00) $display("FAIL wr_rdata got %h want 00", rd); else passed++;
    run_txn(1, 1'b0, 32'h0000_0005, 8'h00, rdy, wt, rsp, rd, lat);
    checks++; if (rdy !== 2'b10) $display("FAIL rd_grant got %b want 10", rdy); else passed++;
    checks++; if (rsp !== 2'b10) $display("FAIL rd_rspport got %b want 10", rsp); else passed++;
    checks++; if (lat != RSP_LAT) $display("FAIL rd_latency got %0d want %0d", lat, RSP_LAT); else passed++;
    checks++; if (rd !== ref_rd(32'h5)) $display("FAIL rd_rdata got %h want %h", rd, ref_rd(32'h5)); else passed++;
  endtask

  task automatic test_waveform();
    logic [1:0]  rdy, rsp;
    logic [7:0]  rd, cmd;
    logic [31:0] adr;
    int wt, lat;
    run_txn(0, 1'b0, 32'h0000_003F, 8'h00, rdy, wt, rsp, rd, lat);
    adr = '0;
    cmd = '0;
    for (int i = 0; i < 32; i++) adr = {adr[30:0], rise_mosi[i]};
    for (int i = 32; i < 40; i++) cmd = {cmd[6:0], rise_mosi[i]};
    checks++; if (last_bits != 48) $display("FAIL wave_rises got %0d want 48", last_bits); else passed++;
    checks++; if (adr !== 32'h0000_003F) $display("FAIL wave_addr got %h want 0000003f", adr); else passed++;
    checks++; if (cmd !== 8'h01) $display("FAIL wave_cmd got %h want 01", cmd); else passed++;
    checks++; if (rd !== ref_rd(32'h3F)) $display("FAIL wave_rdata got %h want %h", rd, ref_rd(32'h3F)); else passed++;
  endtask

  task automatic test_capture();
    logic [1:0] rdy, rsp;
    logic [7:0] rd, v;
    int wt, lat;
    run_txn(1, 1'b1, 32'h0000_0010, 8'hFF, rdy, wt, rsp, rd, lat);
    ref_mem[32'h10] = 8'hFF;
    ovr_en  = 1'b1;
    ovr_val = 8'h81;
    run_txn(0, 1'b0, 32'h0000_0010, 8'h00, rdy, wt, rsp, rd, lat);
    checks++; if (rd !== 8'h81) $display("FAIL capture_81 got %h want 81", rd); else passed++;
    for (int k = 0; k < 3; k++) begin
      v = 8'($urandom);
      ovr_val = v;
      run_txn(k % 2, 1'b0, 32'($urandom_range(0, 255)), 8'h00, rdy, wt, rsp, rd, lat);
      checks++; if (rd !== v) $display("FAIL capture_rand got %h want %h", rd, v); else passed++;
    end
    ovr_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [1:0] rdy, rsp;
    logic [7:0] rd;
    int wt, lat, n, seen;
    @(negedge clk);
    ReqValid[0] = 1'b1; ReqWrite[0] = 1'b1; ReqAdr[0] = 32'h5; ReqWData[0] = 8'h5A;
    @(negedge clk);
    ReqValid[0] = 1'b0;
    n = 0;
    while (fbits < 20 && n < 500) begin @(negedge clk); n++; end
    checks++; if (fbits != 20) $display("FAIL rstmid_reach got %0d want 20", fbits); else passed++;
    reset = 1'b1;
    @(negedge clk);
    reset   = 1'b0;
    ref_ptr = 1'b0;
    #1;
    checks++; if (CS !== 1'b1) $display("FAIL rstmid_cs got %b want 1", CS); else passed++;
    checks++; if (SCK !== 1'b0) $display("FAIL rstmid_sck got %b want 0", SCK); else passed++;
    checks++; if (MOSI !== 1'b0) $display("FAIL rstmid_mosi got %b want 0", MOSI); else passed++;
    seen = 0;
    for (int i = 0; i < RSP_LAT + 10; i++) begin
      if (RspValid !== 2'b00) seen++;
      @(negedge clk); #1;
    end
    checks++; if (seen != 0) $display("FAIL rstmid_norsp got %0d want 0", seen); else passed++;
    run_txn(1, 1'b0, 32'h5, 8'h00, rdy, wt, rsp, rd, lat);
    checks++; if (rd !== ref_rd(32'h5)) $display("FAIL rstmid_olddata got %h want %h", rd, ref_rd(32'h5)); else passed++;
  endtask

  task automatic test_lone_port1();
    logic [1:0] rdy, rsp;
    logic [7:0] rd;
    int wt, lat;
    do_reset();
    run_txn(1, 1'b0, 32'h0000_0005, 8'h00, rdy, wt, rsp, rd, lat);
    checks++; if (rdy !== 2'b10) $display("FAIL lone1_grant got %b want 10", rdy); else passed++;
    checks++; if (wt != 0) $display("FAIL lone1_wait got %0d want 0", wt); else passed++;
    checks++; if (rd !== ref_rd(32'h5)) $display("FAIL lone1_rdata got %h want %h", rd, ref_rd(32'h5)); else passed++;
  endtask

  typedef struct {
    int         port;
    logic [7:0] data;
    int         due;
  } exp_t;

  task automatic test_back_to_back();
    exp_t        q[$];
    exp_t        e;
    bit          pw [2];
    logic [31:0] pa [2];
    logic [7:0]  pd [2];
    int cyc, ngrant, nrsp, g;
    bit twohot;
    for (int p = 0; p < 2; p++) begin
      pw[p] = 1'($urandom_range(0, 1));
      pa[p] = {4'($urandom_range(0, 3)), 24'h0, 4'($urandom_range(0, 3))};
      pd[p] = 8'($urandom);
    end
    cyc = 0; ngrant = 0; nrsp = 0; twohot = 1'b0;
    while (nrsp < NB2B && cyc < NB2B * RSP_LAT + 2000) begin
      @(negedge clk);
      ReqValid = (ngrant < NB2B) ? 2'b11 : 2'b00;
      for (int p = 0; p < 2; p++) begin
        ReqWrite[p] = pw[p];
        ReqAdr[p]   = pa[p];
        ReqWData[p] = pd[p];
      end
      #1;
      if (ReqReady == 2'b11) twohot = 1'b1;
      if (RspValid != 2'b00) begin
        if (q.size() == 0) begin
          checks++; $display("FAIL b2b_unexpected_rsp got %b want none", RspValid);
        end else begin
          e = q.pop_front();
          checks++; if (RspValid !== (2'b01 << e.port)) $display("FAIL b2b_rspport got %b want %b", RspValid, 2'b01 << e.port); else passed++;
          checks++; if (cyc != e.due) $display("FAIL b2b_latency got cycle %0d want %0d", cyc, e.due); else passed++;
          checks++; if (RspRData !== e.data) $display("FAIL b2b_rdata got %h want %h", RspRData, e.data); else passed++;
        end
        nrsp++;
      end
      if (ReqReady != 2'b00 && ReqReady != 2'b11) begin
        g = ReqReady[1] ? 1 : 0;
        checks++; if (g != int'(ref_ptr)) $display("FAIL b2b_grant got %0d want %0d", g, ref_ptr); else passed++;
        e.port = g;
        e.data = pw[g] ? 8'h00 : ref_rd(pa[g]);
        e.due  = cyc + RSP_LAT;
        q.push_back(e);
        if (pw[g]) ref_mem[pa[g]] = pd[g];
        ref_ptr = (g == 0);
        ngrant++;
        pw[g] = 1'($urandom_range(0, 1));
        pa[g] = {4'($urandom_range(0, 3)), 24'h0, 4'($urandom_range(0, 3))};
        pd[g] = 8'($urandom);
      end
      cyc++;
    end
    ReqValid = 2'b00;
    checks++; if (twohot) $display("FAIL b2b_twohot got 1 want 0"); else passed++;
    checks++; if (nrsp != NB2B) $display("FAIL b2b_count got %0d want %0d", nrsp, NB2B); else passed++;
    checks++; if (min_gap != DIV + 1) $display("FAIL cs_gap got %0d want %0d", min_gap, DIV + 1); else passed++;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_waveform();
    test_capture();
    test_reset_mid();
    test_lone_port1();
    test_back_to_back();
    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
